// File: rtl/obstacle_ctl_if.sv
// VGA timing interface consumed by the obstacle controller; only the
// vertical blanking flag is needed to frame-synchronise gate motion.
interface vga_if;
    logic vblnk;

    modport in (input vblnk);
    modport out (output vblnk);
endinterface

// File: rtl/obstacle_ctl.sv
// Gate obstacle controller: lowers, holds and raises the gate once per frame.
// Define OBSTACLE_BOTH_BTN_EN to require both floor buttons (co-op mode).
module obstacle_ctl #(
    parameter int TOP_CLOSED  = 350,
    parameter int TOP_OPEN    = 500,
    parameter int STEP        = 2,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        btn_a,
    input  logic        btn_b,
    output logic [10:0] obs_top,
    output logic        obs_passable,
    output logic [1:0]  obs_state,
    output logic        frame_tick
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              vblnk_d;
    logic              req;
    logic [11:0]       top_ext;
    logic [11:0]       up_sum;
    logic [11:0]       dn_diff;
    logic              at_open;
    logic              at_closed;
    logic [10:0]       top_up;
    logic [10:0]       top_dn;

`ifdef OBSTACLE_BOTH_BTN_EN
    assign req = btn_a & btn_b;
`else
    assign req = btn_a | btn_b;
`endif

    assign obs_state = state;

    // Widen to 12 bits before stepping so the clamp sees the true result
    // rather than a wrapped one; the underflow guard covers tiny positions.
    always_comb begin
        top_ext   = {1'b0, obs_top};
        up_sum    = top_ext + 12'(STEP);
        dn_diff   = top_ext - 12'(STEP);
        at_open   = (up_sum >= 12'(TOP_OPEN));
        at_closed = (top_ext < 12'(STEP)) || (dn_diff <= 12'(TOP_CLOSED));
        top_up    = at_open   ? 11'(TOP_OPEN)   : up_sum[10:0];
        top_dn    = at_closed ? 11'(TOP_CLOSED) : dn_diff[10:0];
    end

    // vblnk_d comes out of reset high so a vblnk already high at release
    // is not mistaken for a fresh frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vga_in.vblnk;
            frame_tick <= vga_in.vblnk & ~vblnk_d;
        end
    end

    // The FSM consumes the registered tick, so the gate moves only at the
    // start of vertical blanking and never mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLOSED;
            obs_top      <= 11'(TOP_CLOSED);
            obs_passable <= 1'b0;
            hold_cnt     <= '0;
        end else if (frame_tick) begin
            case (state)
                CLOSED: begin
                    if (req) begin
                        state <= OPENING;
                    end
                end
                OPENING: begin
                    obs_top <= top_up;
                    if (at_open) begin
                        state        <= OPEN;
                        obs_passable <= 1'b1;
                        hold_cnt     <= HOLD_W'(HOLD_FRAMES);
                    end
                end
                OPEN: begin
                    if (req) begin
                        hold_cnt <= HOLD_W'(HOLD_FRAMES);
                    end else if (hold_cnt == HOLD_W'(1)) begin
                        state        <= CLOSING;
                        obs_passable <= 1'b0;
                        hold_cnt     <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                CLOSING: begin
                    if (req) begin
                        state <= OPENING;
                    end else begin
                        obs_top <= top_dn;
                        if (at_closed) begin
                            state <= CLOSED;
                        end
                    end
                end
            endcase
        end
    end

endmodule
